// File: rtl/apb_master.sv
// APB requester: turns a single-beat command handshake into APB SETUP/ACCESS transfers,
// with PREADY wait states, an optional stuck-transfer timeout and optional late PRDATA capture.
module apb_master #(
  parameter int ADDRESSWIDTH = 4,
  parameter int DATAWIDTH    = 8,
  parameter int TIMEOUT      = 16,
  parameter int RDATA_LATE   = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDRESSWIDTH-1:0] cmd_addr,
  input  logic [DATAWIDTH-1:0]    cmd_wdata,
  output logic                    rsp_valid,
  output logic [DATAWIDTH-1:0]    rsp_rdata,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic [ADDRESSWIDTH-1:0] PADDR,
  output logic [DATAWIDTH-1:0]    PWDATA,
  output logic                    PWRITE,
  output logic                    PSELx,
  output logic                    PENABLE,
  input  logic [DATAWIDTH-1:0]    PRDATA,
  input  logic                    PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, LATE} state_t;

  // Counter value on the last permitted wait cycle; only meaningful when TIMEOUT != 0.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] paddr_q, paddr_d;
  logic [DATAWIDTH-1:0]    pwdata_q, pwdata_d;
  logic                    pwrite_q, pwrite_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATAWIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [7:0]              cnt_q, cnt_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          pwrite_d  = cmd_write;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // PREADY wins over an expiring counter on the same edge.
        if (PREADY) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (RDATA_LATE != 0) begin
            state_d = LATE;
          end else begin
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b0;
            if (!pwrite_q) rsp_rdata_d = PRDATA;
            state_d = IDLE;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == WAIT_LAST)) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = IDLE;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      LATE: begin
        rsp_valid_d   = 1'b1;
        rsp_timeout_d = 1'b0;
        if (!pwrite_q) rsp_rdata_d = PRDATA;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PWRITE      = pwrite_q;
  assign PSELx       = psel_q;
  assign PENABLE     = penable_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: three parameterisations driven by randomized commands and a
// behavioural APB slave; responses are scoreboarded against a transaction-level model.
module tb_apb_master;

  typedef struct {
    bit         wr;
    logic [3:0] a;
    logic [7:0] d;
    int         w;
    logic [7:0] x;
    logic [7:0] y;
    bit         b2b;
    bit         rst;
  } cmd_t;

  typedef struct {
    logic [7:0] rd;
    bit         to;
    int         at;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int T  = (g == 0) ? 4 : (g == 1) ? 3 : 0;
    localparam int LT = (g == 1) ? 1 : 0;

    logic       rst_n = 1'b0;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [3:0] cmd_addr, paddr;
    logic [7:0] cmd_wdata, rsp_rdata, pwdata, prdata;
    logic       rsp_valid, rsp_timeout, busy, pwrite, psel, penable, pready;
    int         cyc = 0;
    bit         done = 1'b0;
    cmd_t       cur;
    cmd_t       cl[$];
    rsp_t       q[$];
    string      pfx;

    apb_master #(.ADDRESSWIDTH(4), .DATAWIDTH(8), .TIMEOUT(T), .RDATA_LATE(LT)) dut (
      .PCLK(clk), .PRESETn(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout), .busy(busy),
      .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite), .PSELx(psel), .PENABLE(penable),
      .PRDATA(prdata), .PREADY(pready)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural slave: holds PREADY low for cur.w ACCESS cycles, returns cur.x when ready,
    // and presents cur.y outside ACCESS (what a late-sampling master must capture).
    initial begin : slave
      int acc;
      acc = 0;
      pready = 1'b0;
      prdata = 8'h00;
      pfx = $sformatf("i%0d", g);
      forever begin
        @(negedge clk);
        chk({pfx, "_penable_implies_psel"}, 32'(penable & ~psel), 32'd0);
        if (psel && penable) begin
          acc++;
          chk({pfx, "_access_paddr"}, 32'(paddr), 32'(cur.a));
          chk({pfx, "_access_pwdata"}, 32'(pwdata), 32'(cur.d));
          chk({pfx, "_access_pwrite"}, 32'(pwrite), 32'(cur.wr));
          if (acc > cur.w) begin
            pready = 1'b1;
            prdata = cur.x;
          end else begin
            pready = 1'b0;
            prdata = 8'($urandom);
          end
        end else begin
          acc = 0;
          pready = 1'($urandom_range(0, 1));
          prdata = cur.y;
        end
      end
    end

    initial begin : monitor
      rsp_t r;
      forever begin
        @(negedge clk);
        if (rsp_valid) begin
          if (q.size() == 0) begin
            chk({pfx, "_rsp_unexpected"}, 32'd1, 32'd0);
          end else begin
            r = q.pop_front();
            chk({pfx, "_rsp_rdata"}, 32'(rsp_rdata), 32'(r.rd));
            chk({pfx, "_rsp_timeout"}, 32'(rsp_timeout), 32'(r.to));
            chk({pfx, "_rsp_cycle"}, 32'(cyc), 32'(r.at));
          end
        end
      end
    end

    initial begin : driver
      cmd_t       c;
      bit         to;
      logic [7:0] erd, hold_rd;
      bit         hold_to;
      int         t, wmax;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cur = '{wr: 1'b0, a: 4'h0, d: 8'h00, w: 0, x: 8'h00, y: 8'h00, b2b: 1'b0, rst: 1'b0};
      hold_rd = 8'h00; hold_to = 1'b0;
      wmax = (T == 0) ? 9 : T + 2;

      cl.push_back('{1'b1, 4'd2, 8'hA5, 0, 8'h11, 8'h22, 1'b0, 1'b0});
      cl.push_back('{1'b0, 4'd3, 8'h00, 3, 8'h3C, 8'hC3, 1'b0, 1'b0});
      cl.push_back('{1'b0, 4'd4, 8'h00, T, 8'h96, 8'h69, 1'b0, 1'b0});
      cl.push_back('{1'b0, 4'd6, 8'h00, (T == 0) ? 7 : T - 1, 8'h4B, 8'hB4, 1'b0, 1'b0});
      cl.push_back('{1'b0, 4'd5, 8'h00, 1, 8'h00, 8'h77, 1'b0, 1'b0});
      cl.push_back('{1'b1, 4'd7, 8'hE1, T + 2, 8'h00, 8'h00, 1'b0, 1'b1});
      cl.push_back('{1'b0, 4'd1, 8'h00, 0, 8'h5A, 8'h5A, 1'b0, 1'b0});
      cl.push_back('{1'b1, 4'd8, 8'h12, 1, 8'h00, 8'h00, 1'b1, 1'b0});
      cl.push_back('{1'b0, 4'd9, 8'h34, 2, 8'hD2, 8'h2D, 1'b1, 1'b0});
      cl.push_back('{1'b1, 4'd10, 8'h56, 0, 8'h00, 8'h00, 1'b0, 1'b0});
      for (int k = 0; k < 40; k++)
        cl.push_back('{1'($urandom), 4'($urandom), 8'($urandom), $urandom_range(0, wmax),
                       8'($urandom), 8'($urandom), 1'($urandom), 1'b0});

      repeat (3) @(negedge clk);
      chk({pfx, "_rst_psel"}, 32'(psel), 32'd0);
      chk({pfx, "_rst_penable"}, 32'(penable), 32'd0);
      chk({pfx, "_rst_paddr"}, 32'(paddr), 32'd0);
      chk({pfx, "_rst_pwdata"}, 32'(pwdata), 32'd0);
      chk({pfx, "_rst_pwrite"}, 32'(pwrite), 32'd0);
      chk({pfx, "_rst_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({pfx, "_rst_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
      chk({pfx, "_rst_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk({pfx, "_post_rst_cmd_ready"}, 32'(cmd_ready), 32'd1);
      chk({pfx, "_post_rst_busy"}, 32'(busy), 32'd0);

      for (int i = 0; i < cl.size(); i++) begin
        c = cl[i];
        if (!cmd_valid) repeat ($urandom_range(0, 2)) @(negedge clk);
        cmd_valid = 1'b1; cmd_write = c.wr; cmd_addr = c.a; cmd_wdata = c.d;
        t = 0;
        while (!cmd_ready && t < 60) begin
          @(negedge clk);
          t++;
        end
        if (!cmd_ready) begin
          chk({pfx, "_accept_wait"}, 32'd0, 32'd1);
          break;
        end
        // Accepted on the coming edge: record what the transfer must produce.
        cur = c;
        to  = (T != 0) && (c.w >= T);
        erd = (!c.wr && !to) ? ((LT != 0) ? c.y : c.x) : hold_rd;
        if (!c.rst) q.push_back('{erd, to, cyc + (to ? T + 2 : c.w + 3 + LT)});

        @(negedge clk);
        chk({pfx, "_setup_psel"}, 32'(psel), 32'd1);
        chk({pfx, "_setup_penable"}, 32'(penable), 32'd0);
        chk({pfx, "_setup_paddr"}, 32'(paddr), 32'(c.a));
        chk({pfx, "_setup_pwdata"}, 32'(pwdata), 32'(c.d));
        chk({pfx, "_setup_pwrite"}, 32'(pwrite), 32'(c.wr));
        chk({pfx, "_setup_busy"}, 32'(busy), 32'd1);
        chk({pfx, "_setup_hold_rdata"}, 32'(rsp_rdata), 32'(hold_rd));
        chk({pfx, "_setup_hold_timeout"}, 32'(rsp_timeout), 32'(hold_to));
        if (c.b2b && (i + 1 < cl.size())) begin
          cmd_write = cl[i+1].wr; cmd_addr = cl[i+1].a; cmd_wdata = cl[i+1].d;
        end else begin
          cmd_valid = 1'b0;
          cmd_write = 1'($urandom); cmd_addr = 4'($urandom); cmd_wdata = 8'($urandom);
        end

        if (c.rst) begin
          @(negedge clk);
          chk({pfx, "_pre_rst_penable"}, 32'(penable), 32'd1);
          #2 rst_n = 1'b0;
          #1;
          chk({pfx, "_midrst_psel"}, 32'(psel), 32'd0);
          chk({pfx, "_midrst_penable"}, 32'(penable), 32'd0);
          chk({pfx, "_midrst_rsp_valid"}, 32'(rsp_valid), 32'd0);
          chk({pfx, "_midrst_busy"}, 32'(busy), 32'd0);
          @(negedge clk);
          chk({pfx, "_midrst_paddr"}, 32'(paddr), 32'd0);
          chk({pfx, "_midrst_pwrite"}, 32'(pwrite), 32'd0);
          chk({pfx, "_midrst_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
          @(negedge clk);
          rst_n = 1'b1;
          hold_rd = 8'h00; hold_to = 1'b0;
          @(negedge clk);
          chk({pfx, "_after_rst_cmd_ready"}, 32'(cmd_ready), 32'd1);
        end else begin
          t = 0;
          do begin
            @(negedge clk);
            t++;
            if (!rsp_valid) begin
              chk({pfx, "_xfer_busy"}, 32'(busy), 32'd1);
              chk({pfx, "_xfer_cmd_ready"}, 32'(cmd_ready), 32'd0);
            end
          end while (!rsp_valid && t < 60);
          if (!rsp_valid) begin
            chk({pfx, "_rsp_wait"}, 32'd0, 32'd1);
            break;
          end
          chk({pfx, "_done_busy"}, 32'(busy), 32'd0);
          chk({pfx, "_done_cmd_ready"}, 32'(cmd_ready), 32'd1);
          chk({pfx, "_done_psel"}, 32'(psel), 32'd0);
          chk({pfx, "_idle_paddr_hold"}, 32'(paddr), 32'(c.a));
          chk({pfx, "_idle_pwrite_hold"}, 32'(pwrite), 32'(c.wr));
          hold_rd = erd; hold_to = to;
        end
      end
      repeat (3) @(negedge clk);
      chk({pfx, "_scoreboard_empty"}, 32'(q.size()), 32'd0);
      done = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(gi[0].done && gi[1].done && gi[2].done) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (!(gi[0].done && gi[1].done && gi[2].done)) chk("bench_complete", 32'd0, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
